// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the sponge controller state type.
package keccak_pkg;

    localparam int unsigned KECCAK_STATE_W   = 1600;
    localparam int unsigned KECCAK_LANE_W    = 64;
    localparam int unsigned KECCAK_ROUNDS    = 24;
    localparam logic [7:0]  KECCAK_PAD_FIRST = 8'h06;
    localparam logic [7:0]  KECCAK_PAD_LAST  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PAD,
        ST_PSTART,
        ST_PRUN,
        ST_SQUEEZE
    } sponge_state_e;

endpackage

// File: rtl/sha3_pad_mask.sv
// Builds the XOR vectors applied to the sponge state: the incoming message
// word (tail bytes of a last word dropped) placed in its lane, and the
// SHA3 domain/padding bytes placed at pad position and end of rate.
module sha3_pad_mask
    import keccak_pkg::*;
#(
    parameter int unsigned P_RATE_LANES = 17
) (
    input  logic [63:0]               i_word,
    input  logic [4:0]                i_lane,
    input  logic [3:0]                i_bytes,
    input  logic [7:0]                i_pad_pos,
    output logic [KECCAK_STATE_W-1:0] o_absorb_vec,
    output logic [KECCAK_STATE_W-1:0] o_pad_vec
);

    logic [63:0] w_masked;

    // Keep only the first i_bytes bytes (byte 0 is the MSB) and drop the word into lane i_lane.
    always_comb begin
        w_masked = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (4'(j) < i_bytes) begin
                w_masked[63-8*j -: 8] = i_word[63-8*j -: 8];
            end
        end
        o_absorb_vec = '0;
        for (int unsigned i = 0; i < P_RATE_LANES; i++) begin
            if (5'(i) == i_lane) begin
                o_absorb_vec[KECCAK_STATE_W-1-KECCAK_LANE_W*i -: KECCAK_LANE_W] = w_masked;
            end
        end
    end

    // 0x06 at byte i_pad_pos, 0x80 at the last rate byte; XOR gives 0x86 when they coincide.
    always_comb begin
        o_pad_vec = '0;
        for (int unsigned b = 0; b < 8*P_RATE_LANES; b++) begin
            if (8'(b) == i_pad_pos) begin
                o_pad_vec[KECCAK_STATE_W-1-8*b -: 8] = KECCAK_PAD_FIRST;
            end
        end
        o_pad_vec[KECCAK_STATE_W-1-8*(8*P_RATE_LANES-1) -: 8] =
            o_pad_vec[KECCAK_STATE_W-1-8*(8*P_RATE_LANES-1) -: 8] ^ KECCAK_PAD_LAST;
    end

endmodule

// File: rtl/sha3_sponge_ctrl.sv
// SHA3 sponge controller: absorbs 64-bit message words into the rate,
// applies SHA3 padding, sequences the one-round Keccak core for 24 rounds
// per block and streams out the digest lanes.
module sha3_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int unsigned P_RATE_LANES = 17,
    parameter int unsigned P_OUT_LANES  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [63:0]               i_msg_data,
    input  logic                      i_msg_valid,
    input  logic                      i_msg_last,
    input  logic [3:0]                i_msg_bytes,
    output logic                      o_msg_ready,
    output logic [KECCAK_STATE_W-1:0] o_perm_state,
    output logic                      o_perm_valid,
    input  logic                      i_perm_ready,
    input  logic [KECCAK_STATE_W-1:0] i_perm_state,
    input  logic                      i_perm_done,
    output logic [63:0]               o_dgst_data,
    output logic                      o_dgst_valid,
    output logic                      o_dgst_last,
    input  logic                      i_dgst_ready,
    output logic                      o_busy
);

    localparam logic [4:0] LP_LAST_LANE  = 5'(P_RATE_LANES - 1);
    localparam logic [4:0] LP_LAST_OUT   = 5'(P_OUT_LANES - 1);
    localparam logic [4:0] LP_LAST_RND   = 5'(KECCAK_ROUNDS - 1);
    localparam logic [7:0] LP_RATE_BYTES = 8'(8 * P_RATE_LANES);

    sponge_state_e             r_fsm;
    sponge_state_e             w_fsm_nxt;
    logic [KECCAK_STATE_W-1:0] r_state;
    logic [4:0]                r_lane_cnt;
    logic [4:0]                r_rnd_cnt;
    logic [4:0]                r_out_cnt;
    logic [7:0]                r_pad_pos;
    logic                      r_pad_pending;
    logic                      r_final;

    logic [3:0]                w_bytes;
    logic [7:0]                w_pad_pos;
    logic                      w_block_full;
    logic [KECCAK_STATE_W-1:0] w_absorb_vec;
    logic [KECCAK_STATE_W-1:0] w_pad_vec;

    // Non-last words are always full; out-of-range byte counts saturate at 8.
    assign w_bytes      = !i_msg_last ? 4'd8 : ((i_msg_bytes > 4'd8) ? 4'd8 : i_msg_bytes);
    assign w_pad_pos    = {r_lane_cnt, 3'b000} + {4'b0000, w_bytes};
    assign w_block_full = (w_pad_pos == LP_RATE_BYTES);
    assign o_perm_state = r_state;

    sha3_pad_mask #(
        .P_RATE_LANES(P_RATE_LANES)
    ) u_pad_mask (
        .i_word       (i_msg_data),
        .i_lane       (r_lane_cnt),
        .i_bytes      (w_bytes),
        .i_pad_pos    (r_pad_pos),
        .o_absorb_vec (w_absorb_vec),
        .o_pad_vec    (w_pad_vec)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE, ST_ABSORB: begin
                if (i_msg_valid) begin
                    if (i_msg_last) begin
                        w_fsm_nxt = w_block_full ? ST_PSTART : ST_PAD;
                    end else if (r_lane_cnt == LP_LAST_LANE) begin
                        w_fsm_nxt = ST_PSTART;
                    end else begin
                        w_fsm_nxt = ST_ABSORB;
                    end
                end
            end
            ST_PAD:    w_fsm_nxt = ST_PSTART;
            ST_PSTART: if (i_perm_ready) w_fsm_nxt = ST_PRUN;
            ST_PRUN: begin
                if (i_perm_done) begin
                    if (r_final)            w_fsm_nxt = ST_SQUEEZE;
                    else if (r_pad_pending) w_fsm_nxt = ST_PAD;
                    else                    w_fsm_nxt = ST_ABSORB;
                end
            end
            ST_SQUEEZE: begin
                if (i_dgst_ready && (r_out_cnt == LP_LAST_OUT)) w_fsm_nxt = ST_IDLE;
            end
            default:   w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Output decode; perm_valid follows ready so the core is never kicked from DONE.
    always_comb begin
        o_msg_ready  = 1'b0;
        o_perm_valid = 1'b0;
        o_dgst_valid = 1'b0;
        o_dgst_last  = 1'b0;
        o_dgst_data  = '0;
        o_busy       = (r_fsm != ST_IDLE);
        case (r_fsm)
            ST_IDLE, ST_ABSORB: o_msg_ready  = 1'b1;
            ST_PSTART:          o_perm_valid = i_perm_ready;
            ST_SQUEEZE: begin
                o_dgst_valid = 1'b1;
                o_dgst_last  = (r_out_cnt == LP_LAST_OUT);
                for (int unsigned i = 0; i < P_OUT_LANES; i++) begin
                    if (5'(i) == r_out_cnt) begin
                        o_dgst_data = r_state[KECCAK_STATE_W-1-KECCAK_LANE_W*i -: KECCAK_LANE_W];
                    end
                end
            end
            default: ;
        endcase
    end

    // Sponge datapath: state register, lane/round/output counters and pad bookkeeping.
    // A last word that exactly fills the block defers padding to a fresh block at byte 0.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state       <= '0;
            r_lane_cnt    <= '0;
            r_rnd_cnt     <= '0;
            r_out_cnt     <= '0;
            r_pad_pos     <= '0;
            r_pad_pending <= 1'b0;
            r_final       <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE, ST_ABSORB: begin
                    if (i_msg_valid) begin
                        r_state <= r_state ^ w_absorb_vec;
                        if (i_msg_last) begin
                            r_lane_cnt <= '0;
                            if (w_block_full) begin
                                r_pad_pending <= 1'b1;
                                r_pad_pos     <= '0;
                            end else begin
                                r_pad_pos <= w_pad_pos;
                            end
                        end else if (r_lane_cnt == LP_LAST_LANE) begin
                            r_lane_cnt <= '0;
                        end else begin
                            r_lane_cnt <= r_lane_cnt + 5'd1;
                        end
                    end
                end
                ST_PAD: begin
                    r_state       <= r_state ^ w_pad_vec;
                    r_final       <= 1'b1;
                    r_pad_pending <= 1'b0;
                end
                ST_PSTART: begin
                    if (i_perm_ready) r_rnd_cnt <= '0;
                end
                ST_PRUN: begin
                    r_state   <= i_perm_state;
                    r_rnd_cnt <= (r_rnd_cnt == LP_LAST_RND) ? '0 : r_rnd_cnt + 5'd1;
                end
                ST_SQUEEZE: begin
                    if (i_dgst_ready) begin
                        if (r_out_cnt == LP_LAST_OUT) begin
                            r_state       <= '0;
                            r_lane_cnt    <= '0;
                            r_rnd_cnt     <= '0;
                            r_out_cnt     <= '0;
                            r_pad_pos     <= '0;
                            r_pad_pending <= 1'b0;
                            r_final       <= 1'b0;
                        end else begin
                            r_out_cnt <= r_out_cnt + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sha3_sponge_ctrl.md
# sha3_sponge_ctrl

Sponge controller that sequences the iterative one-round Keccak-f[1600] core through absorb, pad, permute and squeeze for SHA3-family hashing. It owns the 1600-bit state register, feeds it to the core, and captures the core output each round for 24 rounds. It accepts 64-bit message words on a valid/ready stream and emits digest lanes on a second stream. It sits between the hash front-end (message DMA/buffer) and the `keccakf1600` round core, which the `sha3_top` wrapper connects to it.

## Interface
- `P_RATE_LANES`, 17, rate in 64-bit lanes (17 gives SHA3-256; legal range 1..21).
- `P_OUT_LANES`, 4, digest lanes emitted; must be ≤ `P_RATE_LANES`.
- `i_clk`  in  1  clock; single clock domain.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_msg_data`  in  64  message word; bits [63:56] hold message byte 0.
- `i_msg_valid`  in  1  message word valid.
- `i_msg_last`  in  1  final word of message.
- `i_msg_bytes`  in  4  valid bytes in a last word, 0..8, low-index bytes first. Ignored unless `i_msg_last`.
- `o_msg_ready`  out  1  message word accepted when high with valid.
- `o_perm_state`  out  1600  state to core; always the state register.
- `o_perm_valid`  out  1  start request to core.
- `i_perm_ready`  in  1  core idle.
- `i_perm_state`  in  1600  core one-round output.
- `i_perm_done`  in  1  core final-round flag (round 23).
- `o_dgst_data`  out  64  digest lane, same byte order as message.
- `o_dgst_valid`  out  1  digest lane valid.
- `o_dgst_last`  out  1  final digest lane.
- `i_dgst_ready`  in  1  digest lane accepted.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- State lane i occupies bits [1599-64i -: 64]. Word k of the current block XORs into lane k.
- FSM states: IDLE, ABSORB, PAD, PSTART, PRUN, SQUEEZE.
- IDLE/ABSORB:
  - `o_msg_ready`=1.
  - An accepted word XORs into lane `lane_cnt`. On a last word, bytes at index ≥ `i_msg_bytes` are zeroed first.
  - An accepted word moves IDLE to ABSORB.
  - Non-last word at `lane_cnt`=RATE-1: go to PSTART and clear `lane_cnt`.
  - Last word: go to PAD with pad position p = 8·`lane_cnt` + `i_msg_bytes`.
  - Exception: if p = 8·RATE (last word is full and fills the block), set `pad_pending`, go to PSTART, and use p=0 after the permutation.
- PAD (1 cycle):
  - XOR 0x06 into byte p and 0x80 into byte 8·RATE-1. When the two coincide, the byte receives 0x86.
  - Set `final`, clear `pad_pending`, go to PSTART.
- PSTART:
  - `o_perm_valid` = `i_perm_ready`. Never assert valid while ready is low, because the core restarts on valid in its DONE state.
  - When valid and ready are both high: go to PRUN and clear `rnd_cnt`.
- PRUN:
  - Every cycle, state ← `i_perm_state` and `rnd_cnt`++.
  - On `i_perm_done` (`rnd_cnt`=23), exit to SQUEEZE if `final`, else PAD if `pad_pending`, else ABSORB.
  - `o_msg_ready`=0.
- SQUEEZE:
  - `o_dgst_data` = lane `out_cnt`, `o_dgst_valid`=1, `o_dgst_last` = (`out_cnt`=OUT-1).
  - `out_cnt` advances on handshake.
  - The last handshake zeroes the state register, clears all counters and flags, and returns to IDLE.
- `i_msg_valid` outside IDLE/ABSORB is ignored; no word is lost because ready is low.
- Reset values: state register 0, FSM IDLE, counters 0, `pad_pending`/`final` 0. All outputs low except `o_msg_ready`=1 and `o_perm_state`=0.
- Reset mid-operation aborts the hash with no output. The core shares `i_rstn`.

## Timing
- Words accept 1 per cycle. A block costs RATE accept cycles + 1 PSTART + 24 PRUN when the core is ready.
- Last word accepted at T: T+1 PAD, T+2 PSTART handshake, T+3..T+26 PRUN (done at T+26), T+27 first `o_dgst_valid`.
- After a PRUN exit the core spends 1 cycle in DONE, so the next PSTART may wait one cycle.
- `pad_pending` adds 1 PAD + 1 PSTART + 24 PRUN before squeeze.
- Digest lanes stream 1 per cycle under continuous `i_dgst_ready`. Data and valid are held stable while ready is low.

## Structure
- Shared package `keccak_pkg` holds:
  - constants: state width 1600, lane width 64, round count 24, pad bytes 0x06/0x80;
  - the FSM state enum.
- One combinational sub-module, `sha3_pad_mask`, builds the 1600-bit last-word mask/XOR vector and pad vector from `lane_cnt`, byte count and p.

## Test plan
- Empty message (one beat, last=1, bytes=0) -> first digest lane 64'ha7ffc6f8bf1ed766, full digest a7ffc6f8…434a, latency 27 cycles.
- "abc": data 64'h6162630000000000, bytes=3 -> 3a985da74fe225b2 045c172d6bd390bd 855f086e3e9d525b 46bfe24511431532.
- 136-byte message (17 full words, last on word 17) -> exactly 2 perm handshakes, `pad_pending` path, digest matches golden model.
- 200-byte message with random `i_msg_valid` gaps and `i_dgst_ready` stalls -> digest matches model; no word dropped or duplicated; digest output stable while stalled.
- Hold `i_perm_ready` low in PSTART for 5 cycles -> `o_perm_valid` stays low, FSM waits, result unchanged.
- Assert `i_rstn` low during PRUN round 10 -> all outputs at reset values; a following "abc" hash is correct.
